// File: rtl/instr_queue.sv
// Dual-issue instruction queue: circular buffer between fetch and register read.
// Accepts up to two instructions and retires up to two per cycle, in strict FIFO order.
module instr_queue #(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid1,
    input  logic                       in_valid2,
    input  logic [31:0]                in_instr1,
    input  logic [31:0]                in_instr2,
    input  logic [31:0]                in_pc1,
    input  logic [31:0]                in_pc2,
    output logic                       in_ready,
    output logic                       out_valid1,
    output logic                       out_valid2,
    output logic [31:0]                out_instr1,
    output logic [31:0]                out_instr2,
    output logic [31:0]                out_pc1,
    output logic [31:0]                out_pc2,
    output logic [4:0]                 instr1_rs1,
    output logic [4:0]                 instr1_rs2,
    output logic [4:0]                 instr1_rd,
    output logic [4:0]                 instr2_rs1,
    output logic [4:0]                 instr2_rs2,
    output logic [4:0]                 instr2_rd,
    input  logic                       deq1,
    input  logic                       deq2,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]    instr_mem [DEPTH];
    logic [31:0]    pc_mem    [DEPTH];

    logic [PW-1:0]  head;
    logic [PW-1:0]  tail;
    logic [PW-1:0]  head_p1;
    logic [PW-1:0]  tail_p1;
    logic [1:0]     enq_cnt;
    logic [1:0]     deq_cnt;

    assign head_p1 = head + PW'(1);
    assign tail_p1 = tail + PW'(1);

    // All admission and validity decisions use the registered (pre-edge) count.
    always_comb begin
        in_ready   = (count <= CW'(DEPTH - 2));
        out_valid1 = (count != '0);
        out_valid2 = (count >= CW'(2));

        enq_cnt = 2'd0;
        if (in_ready && in_valid1)
            enq_cnt = in_valid2 ? 2'd2 : 2'd1;

        deq_cnt = 2'd0;
        if (deq1 && out_valid1)
            deq_cnt = (deq2 && out_valid2) ? 2'd2 : 2'd1;
    end

    always_comb begin
        out_instr1 = instr_mem[head];
        out_pc1    = pc_mem[head];
        out_instr2 = instr_mem[head_p1];
        out_pc2    = pc_mem[head_p1];

        instr1_rs1 = out_valid1 ? out_instr1[19:15] : '0;
        instr1_rs2 = out_valid1 ? out_instr1[24:20] : '0;
        instr1_rd  = out_valid1 ? out_instr1[11:7]  : '0;
        instr2_rs1 = out_valid2 ? out_instr2[19:15] : '0;
        instr2_rs2 = out_valid2 ? out_instr2[24:20] : '0;
        instr2_rd  = out_valid2 ? out_instr2[11:7]  : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(deq_cnt);
            tail  <= tail + PW'(enq_cnt);
            count <= count + CW'(enq_cnt) - CW'(deq_cnt);
        end
    end

    // Entry payload carries no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            if (enq_cnt != 2'd0) begin
                instr_mem[tail] <= in_instr1;
                pc_mem[tail]    <= in_pc1;
            end
            if (enq_cnt == 2'd2) begin
                instr_mem[tail_p1] <= in_instr2;
                pc_mem[tail_p1]    <= in_pc2;
            end
        end
    end

endmodule

// File: tb/tb_instr_queue.sv
// Self-checking bench for instr_queue: directed scenarios then random traffic,
// checked against a queue-based reference model.
module tb_instr_queue;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid1 = 1'b0, in_valid2 = 1'b0;
    logic [31:0] in_instr1 = '0, in_instr2 = '0, in_pc1 = '0, in_pc2 = '0;
    logic        deq1 = 1'b0, deq2 = 1'b0;
    logic        in_ready, out_valid1, out_valid2;
    logic [31:0] out_instr1, out_instr2, out_pc1, out_pc2;
    logic [4:0]  instr1_rs1, instr1_rs2, instr1_rd, instr2_rs1, instr2_rs2, instr2_rd;
    logic [CW-1:0] count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: each entry is {instr, pc}.
    logic [63:0] mq[$];

    always #5 clk = ~clk;

    instr_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid1(in_valid1), .in_valid2(in_valid2),
        .in_instr1(in_instr1), .in_instr2(in_instr2),
        .in_pc1(in_pc1), .in_pc2(in_pc2),
        .in_ready(in_ready),
        .out_valid1(out_valid1), .out_valid2(out_valid2),
        .out_instr1(out_instr1), .out_instr2(out_instr2),
        .out_pc1(out_pc1), .out_pc2(out_pc2),
        .instr1_rs1(instr1_rs1), .instr1_rs2(instr1_rs2), .instr1_rd(instr1_rd),
        .instr2_rs1(instr2_rs1), .instr2_rs2(instr2_rs2), .instr2_rd(instr2_rd),
        .deq1(deq1), .deq2(deq2),
        .count(count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int n;
        logic [31:0] i1, i2;
        n = mq.size();
        chk("count", 32'(count), 32'(n));
        chk("in_ready", 32'(in_ready), 32'(n <= DEPTH - 2));
        chk("out_valid1", 32'(out_valid1), 32'(n >= 1));
        chk("out_valid2", 32'(out_valid2), 32'(n >= 2));
        i1 = (n >= 1) ? mq[0][63:32] : 32'h0;
        i2 = (n >= 2) ? mq[1][63:32] : 32'h0;
        if (n >= 1) begin
            chk("out_instr1", out_instr1, i1);
            chk("out_pc1", out_pc1, mq[0][31:0]);
        end
        if (n >= 2) begin
            chk("out_instr2", out_instr2, i2);
            chk("out_pc2", out_pc2, mq[1][31:0]);
        end
        chk("instr1_rs1", 32'(instr1_rs1), 32'(i1[19:15]));
        chk("instr1_rs2", 32'(instr1_rs2), 32'(i1[24:20]));
        chk("instr1_rd",  32'(instr1_rd),  32'(i1[11:7]));
        chk("instr2_rs1", 32'(instr2_rs1), 32'(i2[19:15]));
        chk("instr2_rs2", 32'(instr2_rs2), 32'(i2[24:20]));
        chk("instr2_rd",  32'(instr2_rd),  32'(i2[11:7]));
    endtask

    // Drive one cycle, advance the model with the pre-edge occupancy, then check.
    task automatic step(input logic v1, input logic v2,
                        input logic [31:0] i1, input logic [31:0] p1,
                        input logic [31:0] i2, input logic [31:0] p2,
                        input logic d1, input logic d2,
                        input logic fl, input logic rs);
        int n, ne, nd;
        in_valid1 = v1; in_valid2 = v2;
        in_instr1 = i1; in_pc1 = p1; in_instr2 = i2; in_pc2 = p2;
        deq1 = d1; deq2 = d2; flush = fl; rst = rs;
        @(posedge clk);
        n = mq.size();
        if (rs || fl) begin
            mq.delete();
        end else begin
            ne = (v1 && n <= DEPTH - 2) ? (v2 ? 2 : 1) : 0;
            nd = (d1 && n >= 1) ? ((d2 && n >= 2) ? 2 : 1) : 0;
            for (int k = 0; k < nd; k++) void'(mq.pop_front());
            if (ne >= 1) mq.push_back({i1, p1});
            if (ne == 2) mq.push_back({i2, p2});
        end
        #1;
        check_outputs();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic enq2(input logic [31:0] pc);
        step(1, 1, $urandom, pc, $urandom, pc + 4, 0, 0, 0, 0);
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_count", 32'(count), 32'd0);

        // Single enqueue of add x0,x1,x2
        step(1, 0, 32'h00208033, 32'h100, 0, 0, 0, 0, 0, 0);
        chk("single_rs1", 32'(instr1_rs1), 32'd1);
        chk("single_rs2", 32'(instr1_rs2), 32'd2);
        chk("single_rd", 32'(instr1_rd), 32'd0);
        chk("single_pc", out_pc1, 32'h100);
        chk("single_count", 32'(count), 32'd1);

        // Fill to full, reject fifth dual enqueue, drain in order
        do_reset();
        for (int c = 0; c < 4; c++) enq2(32'h1000 + 32'(c * 8));
        chk("full_count", 32'(count), 32'd8);
        chk("full_ready", 32'(in_ready), 32'd0);
        enq2(32'h2000);
        chk("reject_count", 32'(count), 32'd8);
        for (int c = 0; c < 4; c++) begin
            chk("drain_pc1", out_pc1, 32'h1000 + 32'(c * 8));
            step(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        end

        // Simultaneous enqueue/dequeue with pointer wrap
        do_reset();
        for (int c = 0; c < 3; c++) enq2(32'h3000 + 32'(c * 8));
        for (int c = 0; c < 3; c++) begin
            step(1, 1, $urandom, 32'h4000 + 32'(c * 8), $urandom, 32'h4004 + 32'(c * 8), 1, 1, 0, 0);
            chk("simul_count", 32'(count), 32'd6);
        end

        // Partial ops: over-dequeue from one entry, in_valid2 alone
        do_reset();
        step(1, 0, $urandom, 32'h500, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
        chk("partial_count", 32'(count), 32'd0);
        step(0, 1, $urandom, 0, $urandom, 32'h504, 0, 0, 0, 0);
        chk("v2_only_count", 32'(count), 32'd0);
        step(1, 0, $urandom, 32'h508, 0, 0, 0, 1, 0, 0);

        // Flush with simultaneous dual enqueue
        do_reset();
        enq2(32'h600); enq2(32'h608);
        step(1, 0, $urandom, 32'h610, 0, 0, 0, 0, 0, 0);
        chk("pre_flush_count", 32'(count), 32'd5);
        step(1, 1, $urandom, 32'h700, $urandom, 32'h704, 1, 1, 1, 0);
        chk("flush_valid1", 32'(out_valid1), 32'd0);
        chk("flush_ready", 32'(in_ready), 32'd1);

        // Reset mid-stream
        enq2(32'h800);
        step(1, 0, $urandom, 32'h808, 0, 0, 0, 0, 0, 0);
        step(1, 1, $urandom, 32'h810, $urandom, 32'h814, 1, 0, 1, 1);
        chk("midrst_count", 32'(count), 32'd0);
        step(1, 0, $urandom, 32'h900, 0, 0, 0, 0, 0, 0);
        chk("midrst_pc", out_pc1, 32'h900);

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 $urandom, $urandom, $urandom, $urandom,
                 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 80) == 0));
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/instr_queue.md
INSTR_QUEUE -- requirements
Module: instr_queue

Interface
REQ-001 Parameter DEPTH, default 8, number of queue entries; power of two, at least 4.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous reset, active-high.
REQ-004 flush  input  1  discards all queued entries (branch redirect).
REQ-005 in_valid1 / in_valid2  input  1 each  fetch slots 1 and 2 carry an instruction.
REQ-006 in_instr1 / in_instr2  input  32 each  instruction words.
REQ-007 in_pc1 / in_pc2  input  32 each  instruction PCs.
REQ-008 in_ready  output  1  queue can accept two instructions this cycle.
REQ-009 out_valid1 / out_valid2  output  1 each  head entry and head+1 entry are valid.
REQ-010 out_instr1 / out_instr2, out_pc1 / out_pc2  output  32 each  head and head+1 contents.
REQ-011 instr1_rs1, instr1_rs2, instr1_rd, instr2_rs1, instr2_rs2, instr2_rd  output  5 each  fields [19:15], [24:20] and [11:7] of out_instr1 / out_instr2; they drive the Register_File read-address ports.
REQ-012 deq1 / deq2  input  1 each  the register-read stage consumes the head and head+1 entries.
REQ-013 count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-014 Storage shall be a circular buffer with head and tail pointers of $clog2(DEPTH) bits; both pointers wrap modulo DEPTH.
REQ-015 in_ready shall be 1 when count <= DEPTH-2; it is combinational from the registered count only.
REQ-016 Accepted enqueue count:
- 0 if in_ready=0 or in_valid1=0
- otherwise 1 + in_valid2.
REQ-017 in_valid2 without in_valid1 shall be ignored; nothing is written.
REQ-018 Slot 1 shall be written at tail and slot 2 at tail+1 (mod DEPTH); tail advances by the accepted count.
REQ-019 out_valid1 = (count >= 1); out_valid2 = (count >= 2).
REQ-020 out_* and field outputs shall come from the head entry (1) and the head+1 entry (2), mod DEPTH.
REQ-021 Field outputs shall be zero when the matching out_valid is 0.
REQ-022 Accepted dequeue count:
- 0 if deq1=0 or out_valid1=0
- otherwise 1 + (deq2 & out_valid2).
REQ-023 Illegal dequeue requests (deq2 without deq1, or deq beyond the valid entries) shall be ignored, with no state change for the illegal part.
REQ-024 Enqueue and dequeue in the same cycle shall both take effect: next count = count + accepted_enq - accepted_deq.
REQ-025 Admission and validity decisions shall use the pre-edge count.
REQ-026 There is no bypass: a newly enqueued entry first appears on the outputs the following cycle, even when the queue was empty.
REQ-027 Latency shall be exactly one cycle from in_valid1 acceptance to out_valid1=1 (queue empty).
REQ-028 Order shall be strict FIFO, in_*1 before in_*2; the queue never reorders, drops or duplicates entries.
REQ-029 When flush=1 on an edge, head, tail and count shall be cleared to 0. Flush has priority over simultaneous enqueue and dequeue, and in-cycle inputs are discarded.
REQ-030 Stored entry data need not be cleared by reset or flush; only validity is defined.

Reset
REQ-031 On a rising edge with rst=1, head, tail and count shall become 0.
REQ-032 Output values after that edge: out_valid1=0, out_valid2=0, all field outputs 0, in_ready=1.
REQ-033 rst shall override flush, enqueue and dequeue.
REQ-034 Reset mid-operation shall discard all entries; the first enqueue after reset lands at index 0.

Verification
REQ-035 Single enqueue:
- Reset, then in_valid1=1, in_instr1=0x00208033 (add x0,x1,x2), in_pc1=0x100.
- Next cycle: out_valid1=1, instr1_rs1=1, instr1_rs2=2, instr1_rd=0, out_valid2=0, count=1.
REQ-036 Fill to full:
- Enqueue 2 per cycle for 4 cycles with no deq; count=8 and in_ready=0.
- A fifth dual enqueue is rejected; count stays 8.
- Draining 2 per cycle returns PCs in original order.
REQ-037 Simultaneous enqueue and dequeue:
- Start with count=6; enqueue 2 and dequeue 2 in the same cycle.
- Result: count=6, head and tail each advance by 2, and wrap past index 7 correctly.
REQ-038 Partial ops:
- count=1, deq1=1, deq2=1: only 1 dequeued, count=0.
- in_valid2=1 with in_valid1=0: no change.
REQ-039 Flush:
- Start with count=5; flush=1 together with a dual enqueue.
- Next cycle: count=0, out_valid1=0, in_ready=1.
REQ-040 Reset mid-stream:
- count=3 with traffic active, rst=1 for one edge: count=0.
- The next enqueue appears on out_*1 with the new PC.
